// File: rtl/mips_main.sv
// Single-cycle MIPS-I subset core: PC, 32x32 register file, ALU, decode
// and a 256-byte little-endian data memory, fetching from a parent image.
module mips_main (
    output logic [31:0] next_instruction,
    output logic [31:0] alu_result,
    input  logic [7:0]  instruction_mem [0:255],
    input  logic        clk,
    input  logic        reset
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];
    logic [7:0]  r_dmem [0:255];

    logic [7:0]  w_fa;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic [31:0] w_alu;
    logic        w_we;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;
    logic        w_is_lw;
    logic        w_mem_we;
    logic        w_taken;
    logic        w_jump;
    logic [7:0]  w_ma;
    logic [31:0] w_load;

    // Fetch bytes wrap inside the 256-byte image.
    assign w_fa    = r_pc[7:0];
    assign w_instr = {instruction_mem[w_fa + 8'd3],
                      instruction_mem[w_fa + 8'd2],
                      instruction_mem[w_fa + 8'd1],
                      instruction_mem[w_fa]};

    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_shamt = w_instr[10:6];
    assign w_funct = w_instr[5:0];
    assign w_sext  = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_zext  = {16'h0000, w_instr[15:0]};

    assign w_rs_val = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_alu    = 32'h0;
        w_we     = 1'b0;
        w_wa     = 5'd0;
        w_is_lw  = 1'b0;
        w_mem_we = 1'b0;
        w_taken  = 1'b0;
        w_jump   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_we = 1'b1;
                w_wa = w_rd;
                case (w_funct)
                    6'h20, 6'h21: w_alu = w_rs_val + w_rt_val;
                    6'h22, 6'h23: w_alu = w_rs_val - w_rt_val;
                    6'h24: w_alu = w_rs_val & w_rt_val;
                    6'h25: w_alu = w_rs_val | w_rt_val;
                    6'h26: w_alu = w_rs_val ^ w_rt_val;
                    6'h27: w_alu = ~(w_rs_val | w_rt_val);
                    6'h2A: w_alu = {31'h0, $signed(w_rs_val) < $signed(w_rt_val)};
                    6'h2B: w_alu = {31'h0, w_rs_val < w_rt_val};
                    6'h00: w_alu = w_rt_val << w_shamt;
                    6'h02: w_alu = w_rt_val >> w_shamt;
                    6'h03: w_alu = $signed(w_rt_val) >>> w_shamt;
                    default: w_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                w_alu = w_rs_val + w_sext;
                w_we  = 1'b1;
                w_wa  = w_rt;
            end
            OP_SLTI: begin
                w_alu = {31'h0, $signed(w_rs_val) < $signed(w_sext)};
                w_we  = 1'b1;
                w_wa  = w_rt;
            end
            OP_ANDI: begin
                w_alu = w_rs_val & w_zext;
                w_we  = 1'b1;
                w_wa  = w_rt;
            end
            OP_ORI: begin
                w_alu = w_rs_val | w_zext;
                w_we  = 1'b1;
                w_wa  = w_rt;
            end
            OP_LUI: begin
                w_alu = {w_instr[15:0], 16'h0000};
                w_we  = 1'b1;
                w_wa  = w_rt;
            end
            OP_LW: begin
                w_alu   = w_rs_val + w_sext;
                w_we    = 1'b1;
                w_wa    = w_rt;
                w_is_lw = 1'b1;
            end
            OP_SW: begin
                w_alu    = w_rs_val + w_sext;
                w_mem_we = 1'b1;
            end
            OP_BEQ: begin
                w_alu   = w_rs_val - w_rt_val;
                w_taken = (w_rs_val == w_rt_val);
            end
            OP_BNE: begin
                w_alu   = w_rs_val - w_rt_val;
                w_taken = (w_rs_val != w_rt_val);
            end
            OP_J: w_jump = 1'b1;
            default: ;
        endcase
    end

    // Unaligned word access; each byte address wraps independently.
    assign w_ma   = w_alu[7:0];
    assign w_load = {r_dmem[w_ma + 8'd3], r_dmem[w_ma + 8'd2],
                     r_dmem[w_ma + 8'd1], r_dmem[w_ma]};
    assign w_wd   = w_is_lw ? w_load : w_alu;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jump)
            w_pc_next = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
        else if (w_taken)
            w_pc_next = w_pc_plus4 + {w_sext[29:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= 32'h0;
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'h0;
            for (int i = 0; i < 256; i++)
                r_dmem[i] <= 8'h00;
        end else begin
            r_pc <= w_pc_next;
            if (w_we && (w_wa != 5'd0))
                r_regs[w_wa] <= w_wd;
            if (w_mem_we) begin
                r_dmem[w_ma]        <= w_rt_val[7:0];
                r_dmem[w_ma + 8'd1] <= w_rt_val[15:8];
                r_dmem[w_ma + 8'd2] <= w_rt_val[23:16];
                r_dmem[w_ma + 8'd3] <= w_rt_val[31:24];
            end
        end
    end

    assign next_instruction = w_instr;
    assign alu_result       = w_alu;

endmodule

// File: tb/tb_mips_main.sv
// Bench for mips_main: an ISA-level interpreter predicts each cycle's
// fetched word and ALU result; a negedge monitor drains the expectations.
module tb_mips_main;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  imem [0:255];
    logic [31:0] ni;
    logic [31:0] ar;

    mips_main dut (
        .next_instruction (ni),
        .alu_result       (ar),
        .instruction_mem  (imem),
        .clk              (clk),
        .reset            (reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] res;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_reg [0:31];
    logic [7:0]  m_mem [0:255];

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (ni !== e.ins) begin
                n_fail++;
                $display("FAIL %s instr: got %08h want %08h", e.tag, ni, e.ins);
            end
            n_checks++;
            if (ar !== e.res) begin
                n_fail++;
                $display("FAIL %s alu: got %08h want %08h", e.tag, ar, e.res);
            end
        end
    end

    function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic put_word(int addr, logic [31:0] w);
        for (int k = 0; k < 4; k++)
            imem[(addr + k) % 256] = w[8*k +: 8];
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++)
            imem[i] = 8'h00;
    endtask

    task automatic m_reset();
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
    endtask

    // Executes one instruction of the architectural model.
    task automatic m_step(output logic [31:0] ins, output logic [31:0] res);
        logic [31:0] w, a, b, se, ze, ea, pn, val;
        int op, rs, rt, rd, sh, fn, dst;
        bit wr;
        w = 0;
        for (int k = 0; k < 4; k++)
            w[8*k +: 8] = imem[(m_pc[7:0] + k) % 256];
        op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
        rd = int'(w[15:11]); sh = int'(w[10:6]);  fn = int'(w[5:0]);
        a  = m_reg[rs]; b = m_reg[rt];
        se = {{16{w[15]}}, w[15:0]};
        ze = {16'h0, w[15:0]};
        pn = m_pc + 4;
        res = 0; val = 0; wr = 0; dst = rt;
        case (op)
            0: begin
                wr = 1; dst = rd;
                case (fn)
                    32, 33: val = a + b;
                    34, 35: val = a - b;
                    36: val = a & b;
                    37: val = a | b;
                    38: val = a ^ b;
                    39: val = ~(a | b);
                    42: val = ($signed(a) < $signed(b)) ? 1 : 0;
                    43: val = (a < b) ? 1 : 0;
                    0:  val = b << sh;
                    2:  val = b >> sh;
                    3:  val = $signed(b) >>> sh;
                    default: wr = 0;
                endcase
                res = val;
            end
            8, 9:  begin wr = 1; val = a + se; res = val; end
            10:    begin wr = 1; val = ($signed(a) < $signed(se)) ? 1 : 0; res = val; end
            12:    begin wr = 1; val = a & ze; res = val; end
            13:    begin wr = 1; val = a | ze; res = val; end
            15:    begin wr = 1; val = ze << 16; res = val; end
            35: begin
                ea = a + se; res = ea; wr = 1;
                for (int k = 0; k < 4; k++)
                    val[8*k +: 8] = m_mem[(ea[7:0] + k) % 256];
            end
            43: begin
                ea = a + se; res = ea;
                for (int k = 0; k < 4; k++)
                    m_mem[(ea[7:0] + k) % 256] = b[8*k +: 8];
            end
            4: begin res = a - b; if (a == b) pn = m_pc + 4 + (se << 2); end
            5: begin res = a - b; if (a != b) pn = m_pc + 4 + (se << 2); end
            2: pn = {pn[31:28], w[25:0], 2'b00};
            default: ;
        endcase
        if (wr && dst != 0) m_reg[dst] = val;
        ins  = w;
        m_pc = pn;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
    endtask

    task automatic run(int n, string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            m_step(e.ins, e.res);
            e.tag = $sformatf("%s[%0d]", tag, i + 1);
            q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    // Literal per-cycle expectations; the model still steps to track state.
    task automatic run_fixed(logic [31:0] ins[$], logic [31:0] res[$], string tag);
        exp_t e;
        logic [31:0] di, dr;
        for (int i = 0; i < ins.size(); i++) begin
            m_step(di, dr);
            e.ins = ins[i];
            e.res = res[i];
            e.tag = $sformatf("%s[%0d]", tag, i + 1);
            q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_prog1();
        clear_img();
        put_word(0,  32'h200A000A);
        put_word(4,  32'h200C000B);
        put_word(16, 32'h016A5820);
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rs, rt, rd;
        k  = $urandom_range(0, 19);
        rs = $urandom_range(0, 7);
        rt = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        case (k)
            0:  return enc_r(32 + $urandom_range(0, 7), rs, rt, rd, 0);
            1:  return enc_r(42 + $urandom_range(0, 1), rs, rt, rd, 0);
            2:  return enc_r(0, 0, rt, rd, $urandom_range(0, 31));
            3:  return enc_r(2 + $urandom_range(0, 1), 0, rt, rd, $urandom_range(0, 31));
            4, 5: return enc_i(8 + $urandom_range(0, 1), rs, rt, $urandom);
            6:  return enc_i(10, rs, rt, $urandom);
            7:  return enc_i(12 + $urandom_range(0, 1), rs, rt, $urandom);
            8:  return enc_i(15, 0, rt, $urandom);
            9, 10: return enc_i(35, rs, rt, $urandom);
            11, 12: return enc_i(43, rs, rt, $urandom);
            13: return enc_i(4 + $urandom_range(0, 1), rs, rt, $urandom_range(0, 6) - 3);
            14: return {6'd2, 26'($urandom)};
            15: return enc_r($urandom_range(0, 63), rs, rt, rd, $urandom_range(0, 31));
            16: return $urandom;
            default: return enc_i(9, 0, rt, $urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] fi[$];
        logic [31:0] fr[$];
        clear_img();
        repeat (2) @(posedge clk);
        #1;

        load_prog1();
        do_reset();
        fi = '{32'h200a000a, 32'h200c000b, 0, 0, 32'h016a5820, 0, 0};
        fr = '{32'd10, 32'd11, 0, 0, 32'd10, 0, 0};
        run_fixed(fi, fr, "prog1");

        // Reset mid-program: $11 must restart from 0 (10, not 20).
        load_prog1();
        do_reset();
        run(5, "pre_rst");
        do_reset();
        fi = '{32'h200a000a, 32'h200c000b, 0, 0, 32'h016a5820};
        fr = '{32'd10, 32'd11, 0, 0, 32'd10};
        run_fixed(fi, fr, "post_rst");

        clear_img();
        put_word(0,  enc_i(8, 0, 10, 13));
        put_word(4,  enc_i(8, 0, 11, 10));
        put_word(8,  32'h014B6022);
        put_word(12, 32'hAD4C0000);
        put_word(16, 32'h8D4D0000);
        put_word(20, enc_r(32, 13, 0, 14, 0));
        do_reset();
        fi = '{enc_i(8, 0, 10, 13), enc_i(8, 0, 11, 10), 32'h014B6022,
               32'hAD4C0000, 32'h8D4D0000, enc_r(32, 13, 0, 14, 0)};
        fr = '{32'd13, 32'd10, 32'd3, 32'd13, 32'd13, 32'd3};
        run_fixed(fi, fr, "ldst");

        clear_img();
        put_word(0, enc_i(8, 0, 0, 5));
        put_word(4, enc_r(32, 0, 0, 1, 0));
        do_reset();
        fi = '{enc_i(8, 0, 0, 5), enc_r(32, 0, 0, 1, 0)};
        fr = '{32'd5, 32'd0};
        run_fixed(fi, fr, "zero");

        clear_img();
        put_word(0,  enc_i(8, 0, 1, 1));
        put_word(4,  enc_i(4, 1, 1, 1));
        put_word(8,  enc_i(8, 0, 2, 16'h77));
        put_word(12, enc_i(5, 1, 1, 1));
        put_word(16, enc_i(8, 0, 3, 16'h55));
        do_reset();
        fi = '{enc_i(8, 0, 1, 1), enc_i(4, 1, 1, 1), enc_i(5, 1, 1, 1),
               enc_i(8, 0, 3, 16'h55)};
        fr = '{32'd1, 32'd0, 32'd0, 32'h55};
        run_fixed(fi, fr, "branch");

        clear_img();
        for (int a = 0; a < 252; a += 4)
            put_word(a, enc_i(8, 3, 3, 1));
        put_word(252, 32'h08000000);
        do_reset();
        run(70, "jwrap");

        clear_img();
        for (int a = 0; a < 256; a += 4)
            put_word(a, enc_i(9, 4, 4, a));
        do_reset();
        run(70, "pcwrap");

        for (int p = 0; p < 8; p++) begin
            for (int a = 0; a < 256; a += 4)
                put_word(a, rand_instr());
            do_reset();
            run(150, $sformatf("rnd%0d", p));
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
